dmem_unit: RTL

//  Word-addressed data memory behind the processor's load/store port. Consumes MemWrite/ALUResult/WriteData
//  and returns ReadData via a valid/ready request/response handshake with a programmable wait-state count.

---
 rtl/dmem_pkg.sv | 25 ++
 rtl/dmem_ram.sv | 44 ++++
 rtl/dmem_unit.sv | 138 +++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory unit: FSM state encoding,
// wait-counter width and the byte-enable merge used by the RAM write port.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int WAIT_W     = 4;
  localparam int WORD_BYTES = 4;

  function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// DEPTH x 32 byte-enabled word array: synchronous write, combinational read.
// With DMEM_PARITY_EN defined, one parity bit per byte is stored alongside.
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [3:0]    i_be,
`ifdef DMEM_PARITY_EN
  input  logic [3:0]    i_wpar,
  output logic [3:0]    o_rpar,
`endif
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= be_merge(r_mem[i_waddr], i_wdata, i_be);
  end

  assign o_rdata = r_mem[i_raddr];

`ifdef DMEM_PARITY_EN
  logic [3:0] r_par [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (i_be[i]) r_par[i_waddr][i] <= i_wpar[i];
      end
    end
  end

  assign o_rpar = r_par[i_raddr];
`endif

endmodule

// File: rtl/dmem_unit.sv
// Word-addressed data memory behind the load/store port, with a programmable
// wait-state count. Optional per-byte parity via DMEM_PARITY_EN.
module dmem_unit
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
`ifdef DMEM_PARITY_EN
  input  logic        par_inject,
`endif
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output dmem_state_t o_dbg_state
);

  localparam int                AW        = $clog2(DEPTH);
  localparam logic [31:0]       ADDR_LIM  = 32'(DEPTH * WORD_BYTES);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_CYCLES);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; a response stays stable until it is taken.
  dmem_state_t       r_state, w_next;
  logic [WAIT_W-1:0] r_cnt;
  logic              r_we;
  logic [31:0]       r_addr, r_wdata;
  logic [3:0]        r_be;
  logic [31:0]       r_rdata;
  logic              r_err;

  logic              w_accept, w_enter_resp, w_addr_err, w_ram_we, w_par_err;
  logic [31:0]       w_ram_rdata;

  assign req_ready   = (r_state == IDLE) && !reset;
  assign w_accept    = req_valid && req_ready;
  assign rsp_valid   = (r_state == RESP);
  assign rsp_rdata   = r_rdata;
  assign rsp_err     = r_err;
  assign o_dbg_state = r_state;

  // Out-of-range indices are rejected outright, never wrapped.
  assign w_addr_err = (r_addr[1:0] != 2'b00) || (r_addr >= ADDR_LIM);
  assign w_ram_we   = w_enter_resp && r_we && !w_addr_err;

  always_comb begin
    w_next       = r_state;
    w_enter_resp = 1'b0;
    case (r_state)
      IDLE: if (w_accept) w_next = WAIT;
      WAIT: begin
        if (r_cnt == '0) begin
          w_next       = RESP;
          w_enter_resp = 1'b1;
        end
      end
      RESP:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

`ifdef DMEM_PARITY_EN
  logic       r_inj;
  logic [3:0] w_wpar, w_rpar;

  always_comb begin
    w_wpar    = '0;
    w_par_err = 1'b0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      w_wpar[i] = (^r_wdata[8*i +: 8]) ^ r_inj;
      if ((^w_ram_rdata[8*i +: 8]) != w_rpar[i]) w_par_err = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_inj <= 1'b0;
    else if (w_accept) r_inj <= par_inject;
  end
`else
  assign w_par_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_be    <= req_be;
        r_cnt   <= WAIT_LOAD;
      end else if ((r_state == WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      // Load data and the error flag are captured on the same edge the store commits.
      if (w_enter_resp) begin
        r_err   <= w_addr_err || (!r_we && w_par_err);
        r_rdata <= (r_we || w_addr_err) ? '0 : w_ram_rdata;
      end
    end
  end

  dmem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_waddr (r_addr[AW+1:2]),
    .i_wdata (r_wdata),
    .i_be    (r_be),
`ifdef DMEM_PARITY_EN
    .i_wpar  (w_wpar),
    .o_rpar  (w_rpar),
`endif
    .i_raddr (r_addr[AW+1:2]),
    .o_rdata (w_ram_rdata)
  );

endmodule
